// File: rtl/stopwatch_timebase_if.sv
// Control and display bundle between the stopwatch UI/renderer and the timebase.
// Master drives the user controls; slave (the timebase) drives status and digits.
interface stopwatch_timebase_if;
    logic        start_stop_i;
    logic        lap_i;
    logic        clear_i;
    logic        running_o;
    logic        lap_active_o;
    logic        ovf_o;
    logic        tick_o;
    logic [35:0] disp_bcd_o;
    logic [62:0] disp_seg_o;

    modport master (
        output start_stop_i, lap_i, clear_i,
        input  running_o, lap_active_o, ovf_o, tick_o, disp_bcd_o, disp_seg_o
    );

    modport slave (
        input  start_stop_i, lap_i, clear_i,
        output running_o, lap_active_o, ovf_o, tick_o, disp_bcd_o, disp_seg_o
    );
endinterface

// File: rtl/stopwatch_timebase.sv
// BCD hh:mm:ss.mmm stopwatch with start/stop, lap freeze and clear; 9 digits as BCD + 7-seg.
// Latency: state/count on the event edge, display and tick_o one cycle later.
// Backpressure: none; controls are edge-detected levels, outputs are free-running.
module stopwatch_timebase #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1000
) (
    input  logic               CLK,
    input  logic               rst,
    stopwatch_timebase_if.slave sw
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef struct packed {
        logic [3:0] h1, h0, m1, m0, s1, s0, ms2, ms1, ms0;
    } cnt_t;

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    localparam cnt_t CNT_MAX = 36'h995959999;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    cnt_t          cnt_q, lap_q, disp_src;
    logic          ss_q, lapin_q, clr_q;
    logic          ev_clr, ev_ss, ev_lap;
    logic          clear_all, cap_lap, counting, tick_int;

    // One digit of the ripple: {next digit, carry out}.
    function automatic logic [4:0] dig_inc(input logic [3:0] d, input logic [3:0] dmax,
                                           input logic cin);
        if (!cin)
            return {d, 1'b0};
        else if (d == dmax)
            return {4'd0, 1'b1};
        else
            return {4'(d + 4'd1), 1'b0};
    endfunction

    function automatic cnt_t cnt_inc(input cnt_t c);
        cnt_t n;
        logic cy;
        {n.ms0, cy} = dig_inc(c.ms0, 4'd9, 1'b1);
        {n.ms1, cy} = dig_inc(c.ms1, 4'd9, cy);
        {n.ms2, cy} = dig_inc(c.ms2, 4'd9, cy);
        {n.s0,  cy} = dig_inc(c.s0,  4'd9, cy);
        {n.s1,  cy} = dig_inc(c.s1,  4'd5, cy);
        {n.m0,  cy} = dig_inc(c.m0,  4'd9, cy);
        {n.m1,  cy} = dig_inc(c.m1,  4'd5, cy);
        {n.h0,  cy} = dig_inc(c.h0,  4'd9, cy);
        {n.h1,  cy} = dig_inc(c.h1,  4'd9, cy);
        return n;
    endfunction

    // Mask order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Prioritised events: a clear swallows start/stop and lap on the same cycle.
    assign ev_clr = sw.clear_i & ~clr_q;
    assign ev_ss  = sw.start_stop_i & ~ss_q & ~ev_clr;
    assign ev_lap = sw.lap_i & ~lapin_q & ~ev_clr & ~ev_ss;

    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick_int = counting && (presc_q == PW'(DIV - 1));

    always_comb begin
        state_d   = state_q;
        clear_all = 1'b0;
        cap_lap   = 1'b0;
        if (ev_clr) begin
            state_d   = IDLE;
            clear_all = 1'b1;
        end else if (ev_ss) begin
            case (state_q)
                IDLE, PAUSE: state_d = RUN;
                default:     state_d = PAUSE;
            endcase
        end else if (ev_lap) begin
            if (state_q == RUN) begin
                state_d = LAP;
                cap_lap = 1'b1;
            end else if (state_q == LAP) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= IDLE;
            ss_q      <= 1'b0;
            lapin_q   <= 1'b0;
            clr_q     <= 1'b0;
            presc_q   <= '0;
            cnt_q     <= '0;
            lap_q     <= '0;
            sw.ovf_o  <= 1'b0;
            sw.tick_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            ss_q      <= sw.start_stop_i;
            lapin_q   <= sw.lap_i;
            clr_q     <= sw.clear_i;
            sw.tick_o <= tick_int & ~clear_all;
            if (cap_lap)
                lap_q <= cnt_q;
            if (clear_all) begin
                presc_q  <= '0;
                cnt_q    <= '0;
                lap_q    <= '0;
                sw.ovf_o <= 1'b0;
            end else begin
                // Prescaler holds outside RUN/LAP so a resume keeps the sub-tick phase.
                if (counting)
                    presc_q <= tick_int ? '0 : PW'(presc_q + 1'b1);
                if (tick_int) begin
                    cnt_q <= cnt_inc(cnt_q);
                    if (cnt_q == CNT_MAX)
                        sw.ovf_o <= 1'b1;
                end
            end
        end
    end

    assign disp_src = (state_q == LAP) ? lap_q : cnt_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            sw.disp_bcd_o <= '0;
            sw.disp_seg_o <= {9{7'b0111111}};
        end else begin
            sw.disp_bcd_o <= disp_src;
            sw.disp_seg_o <= {seg7(disp_src.h1),  seg7(disp_src.h0),
                              seg7(disp_src.m1),  seg7(disp_src.m0),
                              seg7(disp_src.s1),  seg7(disp_src.s0),
                              seg7(disp_src.ms2), seg7(disp_src.ms1),
                              seg7(disp_src.ms0)};
        end
    end

    assign sw.running_o    = counting;
    assign sw.lap_active_o = (state_q == LAP);
endmodule

// File: tb/tb_stopwatch_timebase.sv
// Stopwatch timebase bench: directed scenarios then random controls, checked every cycle
// against an elapsed-milliseconds reference model.
module tb_stopwatch_timebase;
    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAXMS   = 100 * 3600000;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    stopwatch_timebase_if sw ();

    stopwatch_timebase #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .CLK (CLK),
        .rst (rst),
        .sw  (sw)
    );

    always #5 CLK = ~CLK;

    // Model: 0 idle, 1 run, 2 lap, 3 pause; time kept as a plain millisecond count.
    int          m_st, m_ph, m_el, m_lap;
    bit          m_ovf, m_tick, m_ssq, m_lapq, m_clrq;
    logic [35:0] m_disp;

    function automatic logic [35:0] to_bcd(input int n);
        int ms, s, m, h;
        ms = n % 1000;
        s  = (n / 1000) % 60;
        m  = (n / 60000) % 60;
        h  = n / 3600000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
    endfunction

    function automatic logic [62:0] to_seg(input logic [35:0] b);
        logic [62:0] r;
        logic [6:0]  t;
        for (int i = 0; i < 9; i++) begin
            case (b[i*4 +: 4])
                4'd0: t = 7'h3F; 4'd1: t = 7'h06; 4'd2: t = 7'h5B; 4'd3: t = 7'h4F;
                4'd4: t = 7'h66; 4'd5: t = 7'h6D; 4'd6: t = 7'h7D; 4'd7: t = 7'h07;
                4'd8: t = 7'h7F; 4'd9: t = 7'h6F; default: t = 7'h00;
            endcase
            r[i*7 +: 7] = t;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ec, es, el, run, tk;
        int old;
        if (rst) begin
            m_st = 0; m_ph = 0; m_el = 0; m_lap = 0; m_ovf = 0; m_tick = 0;
            m_ssq = 0; m_lapq = 0; m_clrq = 0; m_disp = '0;
        end else begin
            ec  = sw.clear_i && !m_clrq;
            es  = sw.start_stop_i && !m_ssq && !ec;
            el  = sw.lap_i && !m_lapq && !ec && !es;
            run = (m_st == 1) || (m_st == 2);
            tk  = run && (m_ph == DIV - 1);
            m_disp = to_bcd((m_st == 2) ? m_lap : m_el);
            m_tick = tk && !ec;
            old = m_el;
            if (run) m_ph = (m_ph + 1) % DIV;
            if (tk) begin
                if (m_el == MAXMS - 1) m_ovf = 1;
                m_el = (m_el + 1) % MAXMS;
            end
            if (ec) begin
                m_st = 0; m_ph = 0; m_el = 0; m_lap = 0; m_ovf = 0;
            end else if (es) begin
                m_st = run ? 3 : 1;
            end else if (el) begin
                if (m_st == 1) begin m_st = 2; m_lap = old; end
                else if (m_st == 2) m_st = 1;
            end
            m_ssq  = sw.start_stop_i;
            m_lapq = sw.lap_i;
            m_clrq = sw.clear_i;
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        chk("running",  sw.running_o,    (m_st == 1) || (m_st == 2));
        chk("lap_act",  sw.lap_active_o, m_st == 2);
        chk("ovf",      sw.ovf_o,        m_ovf);
        chk("tick",     sw.tick_o,       m_tick);
        chk("disp_bcd", sw.disp_bcd_o,   m_disp);
        chk("disp_seg", sw.disp_seg_o,   to_seg(m_disp));
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_ss();
        sw.start_stop_i = 1'b1; cycle();
        sw.start_stop_i = 1'b0; cycle();
    endtask

    task automatic pulse_lap();
        sw.lap_i = 1'b1; cycle();
        sw.lap_i = 1'b0; cycle();
    endtask

    task automatic pulse_clr();
        sw.clear_i = 1'b1; cycle();
        sw.clear_i = 1'b0; cycle();
    endtask

    // Bounded run until the model's elapsed count reaches a target.
    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (m_el != target && n < budget) begin
            cycle();
            n++;
        end
        chk("reach_target", 64'(m_el), 64'(target));
    endtask

    initial begin
        sw.start_stop_i = 1'b0;
        sw.lap_i        = 1'b0;
        sw.clear_i      = 1'b0;
        rst = 1'b1;
        run_n(2);
        chk("rst_bcd", sw.disp_bcd_o, 36'h0);
        chk("rst_seg", sw.disp_seg_o, {9{7'b0111111}});
        rst = 1'b0;

        // Start and watch three ticks.
        pulse_ss();
        run_n(35);

        // Pause at ms0 = 5, idle a while, resume mid-phase.
        run_until(5, 100);
        pulse_ss();
        run_n(50);
        chk("pause_hold", sw.disp_bcd_o, 36'h000000005);
        pulse_ss();
        run_n(30);

        // Preload near the top while paused, then wrap through 99:59:59.999.
        pulse_ss();
        force dut.cnt_q = 36'h995959998;
        m_el = MAXMS - 2;
        cycle();
        release dut.cnt_q;
        run_n(3);
        pulse_ss();
        run_n(25);
        chk("wrap_ovf", sw.ovf_o, 1'b1);
        run_n(15);
        pulse_clr();

        // Lap freeze at 12 while live count advances, then release.
        pulse_ss();
        run_until(12, 200);
        pulse_lap();
        run_n(40);
        chk("lap_frozen", sw.disp_bcd_o, 36'h000000012);
        pulse_lap();
        run_n(5);

        // Clear beats start_stop on the same cycle; then one held start_stop.
        sw.start_stop_i = 1'b1;
        sw.clear_i      = 1'b1;
        cycle();
        sw.clear_i      = 1'b0;
        sw.start_stop_i = 1'b0;
        cycle();
        chk("clr_wins", sw.running_o, 1'b0);
        sw.start_stop_i = 1'b1;
        run_n(20);
        sw.start_stop_i = 1'b0;

        // Walk ms0 through 0..9 and beyond, then reset mid-run.
        run_n(110);
        rst = 1'b1;
        cycle();
        chk("rst_mid_seg", sw.disp_seg_o, {9{7'b0111111}});
        chk("rst_mid_run", sw.running_o, 1'b0);
        rst = 1'b0;

        // Random controls, occasional reset.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) sw.start_stop_i = ~sw.start_stop_i;
            if ($urandom_range(0, 29) == 0) sw.lap_i        = ~sw.lap_i;
            if ($urandom_range(0, 149) == 0) sw.clear_i     = ~sw.clear_i;
            rst = ($urandom_range(0, 799) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
